// File: rtl/tile_fill_controller_pkg.sv
// Shared definitions for the tile fill controller: screen geometry,
// default tile parameters, FSM state encoding and the video-RAM write record.
package tile_fill_controller_pkg;

   localparam int SCREEN_SHIFT       = 8;
   localparam int SCREEN_SIZE        = 1 << SCREEN_SHIFT;
   localparam int TILE_SHIFT_DEFAULT = 6;
   localparam int GRID_SHIFT_DEFAULT = 2;
   localparam int COORD_W            = SCREEN_SHIFT;
   localparam int COLOR_W            = 8;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COLOR_W-1:0] color_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

   // One video-RAM write as it leaves the arbiter.
   typedef struct packed {
      logic   we;
      coord_t col;
      coord_t row;
      color_t color;
   } vram_wr_t;

   // Tile number for a pixel: tiles are numbered row-major across the grid.
   function automatic int tile_index(input coord_t col, input coord_t row,
                                     input int tile_shift, input int grid_shift);
      int tile_x;
      int tile_y;
      tile_x = int'(col) >> tile_shift;
      tile_y = int'(row) >> tile_shift;
      return (tile_y << grid_shift) | tile_x;
   endfunction

endpackage

// File: rtl/tile_fill_controller_vram_write_arbiter.sv
// Arbitrates the single video-RAM write port between the CPU and the tile
// fill engine, and registers the winning write onto the RAM port.
module vram_write_arbiter
   import tile_fill_controller_pkg::*;
(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               i_fill_active,
   input  logic               i_cpu_we,
   input  logic [COORD_W-1:0] i_cpu_col,
   input  logic [COORD_W-1:0] i_cpu_row,
   input  logic [COLOR_W-1:0] i_cpu_color,
   input  logic [COORD_W-1:0] i_fill_col,
   input  logic [COORD_W-1:0] i_fill_row,
   input  logic [COLOR_W-1:0] i_fill_color,
   output logic               o_fill_grant,
   output logic               o_cpu_stall,
   output logic               o_ram_we,
   output logic [COORD_W-1:0] o_ram_col,
   output logic [COORD_W-1:0] o_ram_row,
   output logic [COLOR_W-1:0] o_ram_color
);

   logic     r_prev_cpu;   // last granted write went to the CPU
   vram_wr_t r_ram;
   vram_wr_t w_next;
   logic     w_cpu_grant;
   logic     w_fill_grant;
   logic     w_cpu_stall;

   // Grant decision: CPU always wins outside a fill; during a fill the two
   // requesters take turns so neither can starve the other.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_cpu_grant  = 1'b0;
      w_fill_grant = 1'b0;
      w_cpu_stall  = 1'b0;
      if (!Reset) begin
         if (i_fill_active) begin
            if (i_cpu_we && !r_prev_cpu) begin
               w_cpu_grant = 1'b1;
            end else begin
               w_fill_grant = 1'b1;
               w_cpu_stall  = i_cpu_we;
            end
         end else begin
            w_cpu_grant = i_cpu_we;
         end
      end
   end

   // Select the write that goes to RAM next cycle; address/colour hold when idle.
   always_comb begin
      w_next    = r_ram;
      w_next.we = 1'b0;
      if (w_cpu_grant) begin
         w_next = '{we: 1'b1, col: i_cpu_col, row: i_cpu_row, color: i_cpu_color};
      end else if (w_fill_grant) begin
         w_next = '{we: 1'b1, col: i_fill_col, row: i_fill_row, color: i_fill_color};
      end
   end

   // RAM port register and the turn-taking flag.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         r_ram      <= '0;
         r_prev_cpu <= 1'b0;
      end else begin
         r_ram <= w_next;
         if (w_cpu_grant || w_fill_grant) begin
            r_prev_cpu <= w_cpu_grant;
         end
      end
   end

   assign o_fill_grant = w_fill_grant;
   assign o_cpu_stall  = w_cpu_stall;
   assign o_ram_we     = r_ram.we;
   assign o_ram_col    = r_ram.col;
   assign o_ram_row    = r_ram.row;
   assign o_ram_color  = r_ram.color;

endmodule

// File: rtl/tile_fill_controller.sv
// Full-screen tile fill: on a start request paints the 256x256 screen with a
// grid of solid-colour tiles, sharing the video-RAM write port with the CPU.
module tile_fill_controller
   import tile_fill_controller_pkg::*;
#(
   parameter int TILE_SHIFT = TILE_SHIFT_DEFAULT,  // TILE_SHIFT + GRID_SHIFT must be 8
   parameter int GRID_SHIFT = GRID_SHIFT_DEFAULT
) (
   input  logic                                     Clock,
   input  logic                                     Reset,
   input  logic                                     iStart,
   input  logic [(COLOR_W << (2*GRID_SHIFT))-1:0]   iColors,
   input  logic                                     iCpuWe,
   input  logic [COORD_W-1:0]                       iCpuCol,
   input  logic [COORD_W-1:0]                       iCpuRow,
   input  logic [COLOR_W-1:0]                       iCpuColor,
   output logic                                     oCpuStall,
   output logic                                     oBusy,
   output logic                                     oDone,
   output logic                                     oRamWe,
   output logic [COORD_W-1:0]                       oRamCol,
   output logic [COORD_W-1:0]                       oRamRow,
   output logic [COLOR_W-1:0]                       oRamColor
);

   localparam int SHADOW_W   = COLOR_W << (2*GRID_SHIFT);
   localparam int TILE_IDX_W = 2*GRID_SHIFT;

   fill_state_t           r_state;
   coord_t                r_col;
   coord_t                r_row;
   logic [SHADOW_W-1:0]   r_shadow;   // colours captured at start; immune to iColors changes
   logic                  r_busy;
   logic                  r_done;

   logic                  w_fill_active;
   logic                  w_fill_grant;
   logic                  w_last_pixel;
   logic [TILE_IDX_W-1:0] w_tile_idx;
   color_t                w_fill_color;

   assign w_fill_active = (r_state == ST_FILL);
   assign w_last_pixel  = (r_col == coord_t'(SCREEN_SIZE-1)) && (r_row == coord_t'(SCREEN_SIZE-1));
   assign w_tile_idx    = TILE_IDX_W'(tile_index(r_col, r_row, TILE_SHIFT, GRID_SHIFT));
   assign w_fill_color  = r_shadow[int'(w_tile_idx)*COLOR_W +: COLOR_W];

   // Fill sequencer: raster-order counters advance only on fill grants.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= ST_IDLE;
         r_col    <= '0;
         r_row    <= '0;
         r_shadow <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (iStart) begin
                  r_shadow <= iColors;
                  r_col    <= '0;
                  r_row    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (w_fill_grant) begin
                  if (w_last_pixel) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_col <= r_col + 1'b1;
                     if (r_col == coord_t'(SCREEN_SIZE-1)) begin
                        r_row <= r_row + 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   vram_write_arbiter u_arbiter (
      .Clock        (Clock),
      .Reset        (Reset),
      .i_fill_active(w_fill_active),
      .i_cpu_we     (iCpuWe),
      .i_cpu_col    (iCpuCol),
      .i_cpu_row    (iCpuRow),
      .i_cpu_color  (iCpuColor),
      .i_fill_col   (r_col),
      .i_fill_row   (r_row),
      .i_fill_color (w_fill_color),
      .o_fill_grant (w_fill_grant),
      .o_cpu_stall  (oCpuStall),
      .o_ram_we     (oRamWe),
      .o_ram_col    (oRamCol),
      .o_ram_row    (oRamRow),
      .o_ram_color  (oRamColor)
   );

   assign oBusy = r_busy;
   assign oDone = r_done;

endmodule
